// File: rtl/sub_result_decoder.sv
// Bit-serial inverse of the 4-bit subtractor: rebuilds A = D + B one bit per cycle.
// Define SUB_RESULT_DECODER_ERRCHK_EN to drive ovf from range/negative-zero checks.
module sub_result_decoder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [4:0] s_in,
  input  logic [3:0] b_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] a_out,
  output logic       ovf,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    ADD,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [4:0] s_q;
  logic [4:0] d_sh;
  logic [4:0] b_sh;
  logic [3:0] sum_sh;
  logic       carry;
  logic [2:0] cnt;
  logic [3:0] a_q;
  logic       ovf_q;

  logic       bit_s;
  logic       bit_c;
  logic       last;
  logic       ovf_nxt;

  assign bit_s = d_sh[0] ^ b_sh[0] ^ carry;
  assign bit_c = (d_sh[0] & b_sh[0])
               | (d_sh[0] & carry)
               | (b_sh[0] & carry);
  assign last  = (cnt == 3'd4);

`ifdef SUB_RESULT_DECODER_ERRCHK_EN
  logic neg_zero;
  assign neg_zero = ~s_q[4] & (s_q[3:0] == 4'h0);
  // bit_s is sum[4] on the last ADD cycle
  assign ovf_nxt  = bit_s | neg_zero;
`else
  assign ovf_nxt  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = CONV;
      end
      CONV: begin
        busy      = 1'b1;
        state_nxt = ADD;
      end
      ADD: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q    <= '0;
      d_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      a_q    <= '0;
      ovf_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            s_q  <= s_in;
            b_sh <= {1'b0, b_in};
          end
        end
        CONV: begin
          d_sh  <= s_q[4] ? {1'b0, s_q[3:0]}
                          : ~{1'b0, s_q[3:0]} + 5'd1;
          carry <= 1'b0;
          cnt   <= '0;
        end
        ADD: begin
          d_sh  <= d_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= bit_c;
          cnt   <= cnt + 3'd1;
          // sum[3:0] is complete once bit 4 is being formed
          if (last) begin
            a_q   <= sum_sh;
            ovf_q <= ovf_nxt;
          end else begin
            sum_sh <= {bit_s, sum_sh[3:1]};
          end
        end
        default: ;
      endcase
    end
  end

  assign a_out = a_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_sub_result_decoder.sv
// Bench for sub_result_decoder: directed vector table, backpressure,
// mid-operation reset and randomized round trips against an integer model.
module tb_sub_result_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] s_in;
  logic [3:0] b_in;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] a_out;
  logic       ovf;
  logic       busy;

  int n_chk  = 0;
  int n_fail = 0;

`ifdef SUB_RESULT_DECODER_ERRCHK_EN
  localparam bit ERRCHK = 1'b1;
`else
  localparam bit ERRCHK = 1'b0;
`endif

  sub_result_decoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s_in      (s_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a_out     (a_out),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] s;
    logic [3:0] b;
    logic [3:0] a;
    logic       o_on;
    logic       o_off;
    int         stall;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string nm,
                       input logic [7:0] act,
                       input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void model(input  logic [4:0] s,
                                input  logic [3:0] b,
                                output logic [3:0] a,
                                output logic       o);
    int v;
    int r;
    v = s[4] ? int'(s[3:0]) : -int'(s[3:0]);
    r = v + int'(b);
    a = 4'(r & 15);
    o = ERRCHK && (r < 0 || r > 15 || (!s[4] && s[3:0] == 4'h0));
  endfunction

  task automatic run(input logic [4:0] s,
                     input logic [3:0] b,
                     input logic [3:0] ea,
                     input logic       eo,
                     input int         stall,
                     input string      nm);
    int lat;
    logic [3:0] a0;
    logic       o0;
    @(negedge clk);
    check({nm, " in_ready"}, 8'(in_ready), 8'd1);
    s_in      = s;
    b_in      = b;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    s_in     = 5'($urandom);
    b_in     = 4'($urandom);
    lat = 0;
    while (1) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid || lat >= 20) break;
    end
    check({nm, " latency"}, 8'(lat), 8'd6);
    check({nm, " a_out"}, 8'(a_out), 8'(ea));
    check({nm, " ovf"}, 8'(ovf), 8'(eo));
    a0 = a_out;
    o0 = ovf;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      in_valid = i[0];
      check({nm, " hold"},
            {3'b0, out_valid, in_ready, ovf, 2'b0},
            {3'b0, 1'b1, 1'b0, o0, 2'b0});
      check({nm, " hold a"}, 8'(a_out), 8'(a0));
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({nm, " release"},
          {6'b0, out_valid, in_ready}, {6'b0, 1'b0, 1'b1});
  endtask

  initial begin
    logic [4:0] rs;
    logic [3:0] rb;
    logic [3:0] ma;
    logic       mo;
    logic       seen;

    tbl[0] = '{5'b10011, 4'd4,  4'd7,  1'b0, 1'b0, 0};
    tbl[1] = '{5'b00101, 4'd9,  4'd4,  1'b0, 1'b0, 0};
    tbl[2] = '{5'b00110, 4'd2,  4'hC,  1'b1, 1'b0, 0};
    tbl[3] = '{5'b11111, 4'd15, 4'hE,  1'b1, 1'b0, 0};
    tbl[4] = '{5'b00000, 4'd3,  4'd3,  1'b1, 1'b0, 0};
    tbl[5] = '{5'b10001, 4'd14, 4'hF,  1'b0, 1'b0, 10};
    tbl[6] = '{5'b01111, 4'd0,  4'd1,  1'b1, 1'b0, 0};
    tbl[7] = '{5'b11111, 4'd0,  4'hF,  1'b0, 1'b0, 0};
    tbl[8] = '{5'b00001, 4'd1,  4'd0,  1'b0, 1'b0, 3};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    s_in      = '0;
    b_in      = '0;
    #12;
    check("reset state",
          {in_ready, out_valid, busy, ovf, a_out},
          {1'b1, 1'b0, 1'b0, 1'b0, 4'h0});
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++)
      run(tbl[i].s, tbl[i].b, tbl[i].a,
          ERRCHK ? tbl[i].o_on : tbl[i].o_off,
          tbl[i].stall, $sformatf("vec%0d", i));

    // abort during ADD bit 2
    @(negedge clk);
    s_in      = 5'b10101;
    b_in      = 4'd6;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("busy in add", 8'(busy), 8'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async reset",
          {in_ready, out_valid, busy, ovf, a_out},
          {1'b1, 1'b0, 1'b0, 1'b0, 4'h0});
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      seen = seen | out_valid;
    end
    @(negedge clk);
    rst_n = 1'b1;
    run(5'b10000, 4'd0, 4'd0, 1'b0, 0, "post reset");
    check("abandoned word output", 8'(seen), 8'd0);

    for (int i = 0; i < 40; i++) begin
      rs = 5'($urandom);
      rb = 4'($urandom);
      model(rs, rb, ma, mo);
      run(rs, rb, ma, mo, int'($urandom_range(0, 3)),
          $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
